// File: rtl/seq_array_mult_if.sv
// Operand/result handshake bundle for seq_array_mult.
// The master side supplies operands and consumes products; the slave side is the multiplier.
interface seq_array_mult_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/seq_array_mult.sv
// Iterative shift-and-add WIDTH x WIDTH multiplier, one multiplier bit per clock,
// with optional two's-complement mode and valid/ready handshakes on both sides.
module seq_array_mult #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    seq_array_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [CW-1:0]     cnt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic              neg_res;
    logic [PW-1:0]     prod_r;
    logic              last_bit;
    logic              accept;

    // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        logic signed [WIDTH-1:0] sx;
        sx = $signed(x);
        if (is_signed && (sx < 0))
            return WIDTH'(-sx);
        return x;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                 input logic          neg);
        logic signed [PW-1:0] smag;
        smag = $signed(mag);
        if (neg)
            return PW'(-smag);
        return mag;
    endfunction

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign acc_sum  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid)  next_state = CALC;
            CALC:    if (last_bit)      next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // Control, accumulator and result register: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            prod_r <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt <= '0;
                acc <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                acc <= acc_sum;
                if (last_bit)
                    prod_r <= apply_sign(acc_sum, neg_res);
            end
        end
    end

    // Operand datapath: only meaningful while CALC, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand   <= {{WIDTH{1'b0}}, magnitude(bus.a, bus.signed_mode)};
            mplier  <= magnitude(bus.b, bus.signed_mode);
            neg_res <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end else if (state == CALC) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = prod_r;
endmodule

// File: doc/seq_array_mult.md
Name: seq_array_mult

Overview:
- Parametrised, iterative shift-and-add multiplier. It replaces the fixed 4x4 combinational array with a WIDTH x WIDTH engine that retires one multiplier bit per clock.
- Adds a selectable two's-complement signed mode and valid/ready handshakes on both input and output.
- Sits between an operand source and a result consumer. Both sides use valid/ready flow control, and only one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits; legal range >= 2. Product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair a/b/signed_mode is valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- signed_mode  input  1  1 = a, b and product are two's complement; 0 = unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts the product
- product  output  2*WIDTH  result

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=1 at a rising edge, any state, including mid-CALC):
  - state=IDLE, out_valid=0, product=0, bit counter=0, accumulator=0.
  - In-flight operation is discarded.
  - in_ready=1 from the first cycle after reset.
- in_ready = (state==IDLE), decoded from the state register. out_valid = (state==DONE), registered.
- IDLE:
  - On an edge with in_valid && in_ready: latch signed_mode.
  - Latch |a| and |b| as WIDTH-bit unsigned magnitudes. In signed mode, negative operands are negated; -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - Latch result sign = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear accumulator and counter; go to CALC.
  - If in_valid=0: stay in IDLE; inputs are ignored.
- CALC:
  - Each edge: if the current multiplier LSB is 1, add the shifted multiplicand into the 2*WIDTH accumulator; shift the multiplier right; increment the counter.
  - On the edge completing the WIDTH-th bit: write product = accumulator, or its 2*WIDTH-bit two's-complement negation if result sign=1; go to DONE.
  - Inputs a/b/in_valid are ignored throughout CALC.
- Latency: out_valid rises exactly WIDTH+1 rising edges after the accepting edge (accept edge, WIDTH compute edges, then DONE visible). For WIDTH=8 this is 9 cycles.
- DONE:
  - product and out_valid are held stable until an edge with out_ready=1.
  - On that edge go to IDLE: out_valid=0, in_ready=1 in the next cycle.
  - product retains its last value after pop until the next completion.
  - No new operand is accepted in the same cycle as a result pop; minimum accept-to-accept spacing is WIDTH+2 cycles.
- Arithmetic:
  - No overflow is possible. The unsigned max (2^W-1)^2 fits in 2W bits; the signed extreme (-2^(W-1))^2 = 2^(2W-2) fits in 2W signed.
  - A zero result is never negated to a non-zero value, so 0 stays 0 when result sign=1.
- Changing a, b or signed_mode after acceptance has no effect on the in-flight result.
- Assertions for the verifier:
  - in_ready && out_valid are never both 1.
  - product is unchanged while out_valid && !out_ready.

Test Plan:
- WIDTH=8, unsigned 13*11, out_ready=1 -> in_ready low for 9 cycles after accept, out_valid high on the 9th cycle, product=0x008F, back to IDLE one cycle later.
- Unsigned 255*255 -> 0xFE01; 0*200 -> 0x0000; 1*255 -> 0x00FF.
- Signed mode:
  - -3*5 -> 0xFFF1
  - -128*-128 -> 0x4000
  - -128*127 -> 0xC080
  - 0*-7 -> 0x0000
- Backpressure: complete 6*7 with out_ready=0 for 5 cycles while toggling in_valid and a/b -> product stays 0x002A, out_valid stays 1, in_ready stays 0, no new accept; release out_ready -> single pop.
- Reset mid-operation: accept 100*100, assert rst for one cycle at CALC bit 4 -> out_valid=0, product=0, in_ready=1 next cycle. A following 9*9 yields 0x0051 with correct latency.
- Parameter sweep: WIDTH=2, 4 and 16 random unsigned/signed vectors against a reference model -> all match; out_valid always rises WIDTH+1 edges after accept.
